// File: rtl/ext_frame_ram_arbiter.sv
// ext_frame_ram_arbiter
// Arbitrates one external frame RAM between a deblocking writer and two
// readers (display, motion compensation). Writes win by default; after
// STARVE_MAX back-to-back write grants with a reader waiting, a reader is
// forced through. The two readers share the read slot round-robin.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   wr_req/wr_addr/wr_din/wr_gnt    writer request, address, data, grant
//   disp_req/disp_addr/disp_gnt     display read request, address, grant
//   disp_valid                      display read data valid (grant + 2)
//   mc_req/mc_addr/mc_gnt           MC read request, address, grant
//   mc_valid                        MC read data valid (grant + 2)
//   rd_data                         shared read data, zero unless a valid is high
//   ram_cs_n/ram_wr/ram_addr/ram_din registered RAM command (grant + 1)
//   ram_data                        RAM synchronous read output
//   addr_err                        sticky out-of-range access flag
module ext_frame_ram_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned ADDR_LAST  = 9503
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [13:0] wr_addr,
  input  logic [31:0] wr_din,
  output logic        wr_gnt,
  input  logic        disp_req,
  input  logic [13:0] disp_addr,
  output logic        disp_gnt,
  output logic        disp_valid,
  input  logic        mc_req,
  input  logic [13:0] mc_addr,
  output logic        mc_gnt,
  output logic        mc_valid,
  output logic [31:0] rd_data,
  output logic        ram_cs_n,
  output logic        ram_wr,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_data,
  output logic        addr_err
);

  localparam int unsigned AW = 14;
  localparam int unsigned CW = 4;

  logic [CW-1:0] starve_cnt;
  logic          rr_ptr;      // 0 = display's turn, 1 = MC's turn
  logic          rd_any;
  logic          starved;
  logic          rd_win;
  logic          rd_pick_mc;
  logic          gnt_any;
  logic [AW-1:0] gnt_addr;
  logic          addr_oob;

  // Read pipeline: stage 1 tracks the RAM access cycle, stage 2 the data cycle
  logic          p1_disp;
  logic          p1_mc;
  logic          p1_oob;
  logic          p2_oob;

  // Grant selection; all grants are forced low while in reset
  always_comb begin
    rd_any     = disp_req | mc_req;
    starved    = rd_any && (starve_cnt == CW'(STARVE_MAX));
    wr_gnt     = reset_n & wr_req & ~starved;
    rd_win     = reset_n & rd_any & ~(wr_req & ~starved);
    // Pointed-to reader wins if requesting, otherwise the other one
    rd_pick_mc = rr_ptr ? mc_req : ~disp_req;
    disp_gnt   = rd_win & ~rd_pick_mc;
    mc_gnt     = rd_win & rd_pick_mc;
    gnt_any    = wr_gnt | disp_gnt | mc_gnt;
    gnt_addr   = wr_gnt ? wr_addr : (mc_gnt ? mc_addr : disp_addr);
    addr_oob   = gnt_any && (gnt_addr > AW'(ADDR_LAST));
  end

  // Out-of-range reads still produce a valid, but with zeroed data
  always_comb begin
    rd_data = '0;
    if ((disp_valid | mc_valid) && !p2_oob) begin
      rd_data = ram_data;
    end
  end

  // Arbitration state, RAM command register and read pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      rr_ptr     <= 1'b0;
      ram_cs_n   <= 1'b1;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      addr_err   <= 1'b0;
      p1_disp    <= 1'b0;
      p1_mc      <= 1'b0;
      p1_oob     <= 1'b0;
      p2_oob     <= 1'b0;
      disp_valid <= 1'b0;
      mc_valid   <= 1'b0;
    end else begin
      if (disp_gnt || mc_gnt || !rd_any) begin
        starve_cnt <= '0;
      end else if (wr_gnt && (starve_cnt < CW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CW'(1);
      end

      // After a reader grant, point at the reader that was not served
      if (disp_gnt || mc_gnt) begin
        rr_ptr <= disp_gnt;
      end

      ram_cs_n <= ~(gnt_any & ~addr_oob);
      ram_wr   <= wr_gnt & ~addr_oob;
      if (gnt_any) begin
        ram_addr <= gnt_addr;
      end
      if (wr_gnt) begin
        ram_din <= wr_din;
      end

      if (addr_oob) begin
        addr_err <= 1'b1;
      end

      p1_disp    <= disp_gnt;
      p1_mc      <= mc_gnt;
      p1_oob     <= addr_oob & (disp_gnt | mc_gnt);
      disp_valid <= p1_disp;
      mc_valid   <= p1_mc;
      p2_oob     <= p1_oob;
    end
  end

endmodule

// File: tb/tb_ext_frame_ram_arbiter.sv
// Testbench for ext_frame_ram_arbiter: directed steps with a read-data
// scoreboard and a behavioural synchronous RAM.
module tb_ext_frame_ram_arbiter;

  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned ADDR_LAST  = 9503;

  logic        clk;
  logic        reset_n;
  logic        wr_req;
  logic [13:0] wr_addr;
  logic [31:0] wr_din;
  logic        wr_gnt;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_gnt;
  logic        disp_valid;
  logic        mc_req;
  logic [13:0] mc_addr;
  logic        mc_gnt;
  logic        mc_valid;
  logic [31:0] rd_data;
  logic        ram_cs_n;
  logic        ram_wr;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_data = 32'h0;
  logic        addr_err;

  typedef struct {
    logic        is_mc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [31:0] mem [0:16383];

  ext_frame_ram_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .ADDR_LAST (ADDR_LAST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_din    (wr_din),
    .wr_gnt    (wr_gnt),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_gnt  (disp_gnt),
    .disp_valid(disp_valid),
    .mc_req    (mc_req),
    .mc_addr   (mc_addr),
    .mc_gnt    (mc_gnt),
    .mc_valid  (mc_valid),
    .rd_data   (rd_data),
    .ram_cs_n  (ram_cs_n),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_data  (ram_data),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned a);
    return 32'h9E370000 + 32'(a) * 32'd7;
  endfunction

  // Behavioural synchronous RAM
  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (ram_wr) mem[ram_addr] = ram_din;
      else        ram_data <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    reset_n  = 1'b0;
    wr_req   = 1'b0;
    disp_req = 1'b0;
    mc_req   = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
    end
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: grant legality every cycle, read data against the scoreboard
  always @(negedge clk) begin
    logic bad;
    exp_t e;
    bad = ($countones({wr_gnt, disp_gnt, mc_gnt}) > 1) ||
          (wr_gnt && !wr_req) || (disp_gnt && !disp_req) || (mc_gnt && !mc_req) ||
          (!reset_n && (wr_gnt || disp_gnt || mc_gnt));
    chk("gnt_legal", 32'(bad), 32'd0);
    if (disp_valid || mc_valid) begin
      chk("valid_onehot", 32'(disp_valid & mc_valid), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("valid_kind", 32'(mc_valid), 32'(e.is_mc));
        chk("rd_data", rd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_g;
    for (int i = 0; i < 16384; i++) mem[i] = pat(i);
    mem[5] = 32'hA5A5A5A5;

    reset_n   = 1'b0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_din    = '0;
    disp_req  = 1'b1;
    disp_addr = 14'd5;
    mc_req    = 1'b0;
    mc_addr   = '0;

    // Reset state, grants blocked while a request is present
    sample();
    chk("rst_disp_gnt", 32'(disp_gnt), 32'd0);
    chk("rst_ram_cs_n", 32'(ram_cs_n), 32'd1);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_mc_valid", 32'(mc_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    tick();
    reset_n  = 1'b1;
    disp_req = 1'b0;

    // Single display read
    tick();
    disp_req  = 1'b1;
    disp_addr = 14'd5;
    sb.push_back('{1'b0, 32'hA5A5A5A5});
    sample();
    chk("t1_gnt", 32'({wr_gnt, disp_gnt, mc_gnt}), 32'b010);
    tick();
    disp_req = 1'b0;
    sample();
    chk("t1_cs_n", 32'(ram_cs_n), 32'd0);
    chk("t1_ram_wr", 32'(ram_wr), 32'd0);
    chk("t1_ram_addr", 32'(ram_addr), 32'd5);
    tick();
    sample();
    chk("t1_disp_valid", 32'(disp_valid), 32'd1);
    chk("t1_rd_data", rd_data, 32'hA5A5A5A5);
    drain();

    // Write priority with anti-starvation
    do_reset();
    tick();
    wr_req    = 1'b1;
    wr_addr   = 14'd300;
    wr_din    = 32'hDEADBEEF;
    disp_req  = 1'b1;
    disp_addr = 14'd100;
    mc_req    = 1'b1;
    mc_addr   = 14'd200;
    for (int c = 0; c < 18; c++) begin
      sample();
      if (c == 8) begin
        exp_g = 3'b010;
        sb.push_back('{1'b0, pat(100)});
      end else if (c == 17) begin
        exp_g = 3'b001;
        sb.push_back('{1'b1, pat(200)});
      end else begin
        exp_g = 3'b100;
      end
      chk($sformatf("t2_gnt_c%0d", c), 32'({wr_gnt, disp_gnt, mc_gnt}), 32'(exp_g));
      tick();
    end
    wr_req   = 1'b0;
    disp_req = 1'b0;
    mc_req   = 1'b0;
    drain();

    // Reader round-robin
    do_reset();
    tick();
    disp_req  = 1'b1;
    disp_addr = 14'd40;
    mc_req    = 1'b1;
    mc_addr   = 14'd41;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (c % 2 == 1) begin
        exp_g = 3'b001;
        sb.push_back('{1'b1, pat(41)});
      end else begin
        exp_g = 3'b010;
        sb.push_back('{1'b0, pat(40)});
      end
      chk($sformatf("t3_gnt_c%0d", c), 32'({wr_gnt, disp_gnt, mc_gnt}), 32'(exp_g));
      tick();
    end
    disp_req = 1'b0;
    mc_req   = 1'b0;
    drain();

    // Last legal address, then first illegal one
    tick();
    mc_req  = 1'b1;
    mc_addr = 14'(ADDR_LAST);
    sample();
    chk("t4_gnt_last", 32'(mc_gnt), 32'd1);
    sb.push_back('{1'b1, pat(ADDR_LAST)});
    tick();
    mc_addr = 14'(ADDR_LAST + 1);
    sample();
    chk("t4_gnt_oob", 32'(mc_gnt), 32'd1);
    chk("t4_cs_n_last", 32'(ram_cs_n), 32'd0);
    chk("t4_err_before", 32'(addr_err), 32'd0);
    sb.push_back('{1'b1, 32'd0});
    tick();
    mc_req = 1'b0;
    sample();
    chk("t4_cs_n_oob", 32'(ram_cs_n), 32'd1);
    chk("t4_err_set", 32'(addr_err), 32'd1);
    drain();
    chk("t4_err_sticky", 32'(addr_err), 32'd1);
    do_reset();
    sample();
    chk("t4_err_cleared", 32'(addr_err), 32'd0);

    // Reset one cycle after a display grant discards the read
    tick();
    disp_req  = 1'b1;
    disp_addr = 14'd7;
    sample();
    chk("t5_gnt", 32'(disp_gnt), 32'd1);
    tick();
    disp_req = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("t5_cs_n", 32'(ram_cs_n), 32'd1);
    chk("t5_ram_addr", 32'(ram_addr), 32'd0);
    sample();
    chk("t5_disp_valid_rst", 32'(disp_valid), 32'd0);
    chk("t5_rd_data_rst", rd_data, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk($sformatf("t5_no_valid_c%0d", c), 32'(disp_valid), 32'd0);
      tick();
    end

    // Write then read of the same address
    wr_req  = 1'b1;
    wr_addr = 14'h1000;
    wr_din  = 32'h12345678;
    sample();
    chk("t6_wr_gnt", 32'(wr_gnt), 32'd1);
    tick();
    wr_req  = 1'b0;
    mc_req  = 1'b1;
    mc_addr = 14'h1000;
    sample();
    chk("t6_mc_gnt", 32'(mc_gnt), 32'd1);
    chk("t6_ram_wr", 32'(ram_wr), 32'd1);
    chk("t6_ram_addr", 32'(ram_addr), 32'h1000);
    chk("t6_ram_din", ram_din, 32'h12345678);
    sb.push_back('{1'b1, 32'h12345678});
    tick();
    mc_req = 1'b0;
    sample();
    chk("t6_rd_cmd", 32'({ram_cs_n, ram_wr}), 32'b00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
